// File: rtl/nvdla_sdp_wdma_pkg.sv
// Shared types and constants for the SDP write-DMA burst engine.
//   wdma_state_e : sequencing FSM states
//   PD_CMD/PD_DAT: value of the type bit (bit DW) of a request beat
//   CMD_*        : command field positions, relative to the top of the address
//   cnt_width()  : bits needed to hold 0..max_val inclusive
package nvdla_sdp_wdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } wdma_state_e;

  localparam logic PD_CMD = 1'b0;
  localparam logic PD_DAT = 1'b1;

  // Command payload: [AW-1:0] addr, [AW+3:AW] size (atoms-1), [AW+4] require_ack.
  localparam int CMD_SIZE_OFS = 0;
  localparam int CMD_SIZE_W   = 4;
  localparam int CMD_ACK_OFS  = 4;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int OUTS_W_DEF = cnt_width(16);

endpackage

// File: rtl/nvdla_sdp_wdma_credit.sv
// Outstanding-burst counter for the write-DMA engine.
//   clr   : clears the count (layer start)
//   inc   : a command was accepted
//   dec   : a write completion returned
//   full  : MAX_OUTS bursts in flight, no further command may issue
//   empty : nothing in flight
module nvdla_sdp_wdma_credit
  import nvdla_sdp_wdma_pkg::*;
#(
  parameter int MAX_OUTS = 16,
  parameter int OUTS_W   = cnt_width(MAX_OUTS)
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [OUTS_W-1:0] count;

  // A completion with nothing in flight cannot be ours (e.g. it belongs to a
  // layer aborted by reset), so it never underflows the counter.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == OUTS_W'(MAX_OUTS));
  assign empty = (count == '0);

endmodule

// File: rtl/nvdla_sdp_wdma_burst_engine.sv
// SDP write-DMA burst engine: walks a surface line by line, splits each line
// into bursts of up to MAX_BURST atoms and issues cmd + data beats on the
// interface chosen by cfg_ram_type, limited by outstanding-burst credit.
//   op_en, cfg_*          : start request and layer configuration (latched at start)
//   dp_valid/ready/pd     : upstream atom stream, passed straight through in DATA
//   mcif_*/cvif_*         : request channel and completion pulse per interface
//   done, intr_pvld       : one-cycle pulse once every completion has returned
//   intr_ptr              : cfg_intr_ptr latched at start
//   stall_cnt             : saturating count of selected valid && !ready cycles
//
// state    | meaning
// ST_IDLE  | waiting for op_en; latches config on start
// ST_CMD   | presenting burst command (held while credit is exhausted)
// ST_DATA  | passing size+1 data beats from dp to the selected interface
// ST_DRAIN | all bursts issued, waiting for outstanding completions
// ST_DONE  | one-cycle done / interrupt pulse
module nvdla_sdp_wdma_burst_engine
  import nvdla_sdp_wdma_pkg::*;
#(
  parameter int DW        = 256,
  parameter int AW        = 64,
  parameter int ATOM_LOG2 = 5,
  parameter int MAX_BURST = 4,
  parameter int MAX_OUTS  = 16,
  parameter int CNT_W     = 13
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      op_en,
  input  logic                      cfg_ram_type,
  input  logic [AW-ATOM_LOG2-1:0]   cfg_base_addr,
  input  logic [AW-ATOM_LOG2-1:0]   cfg_line_stride,
  input  logic [CNT_W-1:0]          cfg_width,
  input  logic [CNT_W-1:0]          cfg_height,
  input  logic                      cfg_intr_ptr,
  input  logic                      cfg_perf_en,
  input  logic                      dp_valid,
  output logic                      dp_ready,
  input  logic [DW-1:0]             dp_pd,
  output logic                      mcif_req_valid,
  input  logic                      mcif_req_ready,
  output logic [DW:0]               mcif_req_pd,
  input  logic                      mcif_rsp_complete,
  output logic                      cvif_req_valid,
  input  logic                      cvif_req_ready,
  output logic [DW:0]               cvif_req_pd,
  input  logic                      cvif_rsp_complete,
  output logic                      done,
  output logic                      intr_pvld,
  output logic                      intr_ptr,
  output logic [31:0]               stall_cnt
);

  localparam int AAW = AW - ATOM_LOG2;

  wdma_state_e              state, state_nxt;
  logic                     ram_type_q, perf_en_q;
  logic [AAW-1:0]           line_base_q, stride_q;
  logic [CNT_W-1:0]         width_q, height_q, line_q, offset_q;
  logic [CMD_SIZE_W-1:0]    beat_q;

  logic                     op_load, cmd_acc, beat_acc;
  logic                     req_valid;
  logic [DW:0]              req_pd, cmd_pd;
  logic                     sel_ready, sel_rsp, cr_full, cr_empty;

  logic [CNT_W:0]           rem;
  logic                     last_in_line, last_beat;
  logic [CMD_SIZE_W-1:0]    burst_size;
  logic [AAW-1:0]           atom_addr;

  assign sel_ready = ram_type_q ? mcif_req_ready    : cvif_req_ready;
  assign sel_rsp   = ram_type_q ? mcif_rsp_complete : cvif_rsp_complete;

  // Atoms left in the current line; the last burst of a line takes the remainder.
  assign rem          = {1'b0, width_q} + (CNT_W+1)'(1) - {1'b0, offset_q};
  assign last_in_line = (rem <= (CNT_W+1)'(MAX_BURST));
  assign burst_size   = last_in_line ? CMD_SIZE_W'(rem - 1'b1) : CMD_SIZE_W'(MAX_BURST - 1);
  assign last_beat    = (beat_q == burst_size);

  // line_base_q tracks base + line*stride, so the address is one add; it wraps in atom units.
  assign atom_addr = line_base_q + AAW'(offset_q);

  always_comb begin
    cmd_pd = '0;
    cmd_pd[AW-1:0] = {atom_addr, {ATOM_LOG2{1'b0}}};
    cmd_pd[AW+CMD_SIZE_OFS +: CMD_SIZE_W] = burst_size;
    cmd_pd[AW+CMD_ACK_OFS] = 1'b1;
    cmd_pd[DW] = PD_CMD;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    req_pd    = '0;
    dp_ready  = 1'b0;
    op_load   = 1'b0;
    cmd_acc   = 1'b0;
    beat_acc  = 1'b0;
    done      = 1'b0;
    intr_pvld = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_en) begin
          op_load   = 1'b1;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        req_valid = !cr_full;
        req_pd    = cmd_pd;
        if (!cr_full && sel_ready) begin
          cmd_acc   = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        req_valid = dp_valid;
        dp_ready  = sel_ready;
        req_pd    = {PD_DAT, dp_pd};
        if (dp_valid && sel_ready) begin
          beat_acc = 1'b1;
          if (last_beat) begin
            state_nxt = (last_in_line && line_q == height_q) ? ST_DRAIN : ST_CMD;
          end
        end
      end
      ST_DRAIN: begin
        if (cr_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        intr_pvld = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state       <= ST_IDLE;
      ram_type_q  <= 1'b0;
      perf_en_q   <= 1'b0;
      line_base_q <= '0;
      stride_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      line_q      <= '0;
      offset_q    <= '0;
      beat_q      <= '0;
      intr_ptr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (op_load) begin
        ram_type_q  <= cfg_ram_type;
        perf_en_q   <= cfg_perf_en;
        line_base_q <= cfg_base_addr;
        stride_q    <= cfg_line_stride;
        width_q     <= cfg_width;
        height_q    <= cfg_height;
        intr_ptr    <= cfg_intr_ptr;
        line_q      <= '0;
        offset_q    <= '0;
        beat_q      <= '0;
      end else if (beat_acc) begin
        if (last_beat) begin
          beat_q <= '0;
          if (last_in_line) begin
            offset_q    <= '0;
            line_q      <= line_q + 1'b1;
            line_base_q <= line_base_q + stride_q;
          end else begin
            offset_q <= offset_q + CNT_W'(MAX_BURST);
          end
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // Kept after done for software to read; only the next layer start clears it.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if (op_load) begin
      stall_cnt <= '0;
    end else if (perf_en_q && req_valid && !sel_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign mcif_req_valid = ram_type_q  && req_valid;
  assign cvif_req_valid = !ram_type_q && req_valid;
  assign mcif_req_pd    = ram_type_q ? req_pd : '0;
  assign cvif_req_pd    = ram_type_q ? '0 : req_pd;

  nvdla_sdp_wdma_credit #(
    .MAX_OUTS (MAX_OUTS)
  ) u_credit (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (op_load),
    .inc             (cmd_acc),
    .dec             (sel_rsp),
    .full            (cr_full),
    .empty           (cr_empty)
  );

endmodule

// File: tb/tb_nvdla_sdp_wdma_burst_engine.sv
module tb_nvdla_sdp_wdma_burst_engine;

  localparam int DW  = 256;
  localparam int AW  = 64;
  localparam int AL  = 5;
  localparam int MB  = 4;
  localparam int MO  = 2;
  localparam int CW  = 13;
  localparam int AAW = AW - AL;

  localparam int P_LOAD  = 0;
  localparam int P_CMD   = 1;
  localparam int P_DATA  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;
  localparam int P_END   = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            op_en, cfg_ram_type, cfg_intr_ptr, cfg_perf_en;
  logic [AAW-1:0]  cfg_base_addr, cfg_line_stride;
  logic [CW-1:0]   cfg_width, cfg_height;
  logic            dp_valid, dp_ready;
  logic [DW-1:0]   dp_pd;
  logic            mcif_req_valid, mcif_req_ready, mcif_rsp_complete;
  logic            cvif_req_valid, cvif_req_ready, cvif_rsp_complete;
  logic [DW:0]     mcif_req_pd, cvif_req_pd;
  logic            done, intr_pvld, intr_ptr;
  logic [31:0]     stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]   exp_addr[$];
  int              exp_size[$];

  always #5 clk = ~clk;

  nvdla_sdp_wdma_burst_engine #(
    .DW(DW), .AW(AW), .ATOM_LOG2(AL), .MAX_BURST(MB), .MAX_OUTS(MO), .CNT_W(CW)
  ) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .op_en             (op_en),
    .cfg_ram_type      (cfg_ram_type),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_line_stride   (cfg_line_stride),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .cfg_intr_ptr      (cfg_intr_ptr),
    .cfg_perf_en       (cfg_perf_en),
    .dp_valid          (dp_valid),
    .dp_ready          (dp_ready),
    .dp_pd             (dp_pd),
    .mcif_req_valid    (mcif_req_valid),
    .mcif_req_ready    (mcif_req_ready),
    .mcif_req_pd       (mcif_req_pd),
    .mcif_rsp_complete (mcif_rsp_complete),
    .cvif_req_valid    (cvif_req_valid),
    .cvif_req_ready    (cvif_req_ready),
    .cvif_req_pd       (cvif_req_pd),
    .cvif_rsp_complete (cvif_rsp_complete),
    .done              (done),
    .intr_pvld         (intr_pvld),
    .intr_ptr          (intr_ptr),
    .stall_cnt         (stall_cnt)
  );

  // One layer, checked cycle by cycle against a transaction-level model:
  // expected burst list from the surface geometry, a count of bursts in
  // flight, and the expected stall total.
  // rsp_mode: 0 random completions, 1 withhold until credit-blocked 4 cycles,
  //           2 complete exactly while a command is being offered.
  task automatic run_layer(input logic rt, input int w, input int h,
                           input logic [AAW-1:0] base, input logic [AAW-1:0] stride,
                           input logic ip, input logic pe, input int rdy_pct,
                           input int rsp_mode, input logic hold_op, input int abort_beats);
    int phase, burst, beat, nbeats, outs, blocked, cyc, nb;
    logic [31:0] exp_stall;
    logic sel_rdy, pulse, exp_v, sv, uv, cmd_acc;
    logic [DW:0] spd, upd, epd;
    logic [AAW-1:0] a;
    exp_addr.delete();
    exp_size.delete();
    for (int l = 0; l <= h; l++) begin
      for (int o = 0; o <= w; o += MB) begin
        a = base + stride * AAW'(l) + AAW'(o);
        exp_addr.push_back({a, {AL{1'b0}}});
        exp_size.push_back((((w + 1 - o) < MB) ? (w + 1 - o) : MB) - 1);
      end
    end
    nb = exp_addr.size();
    phase = P_LOAD; burst = 0; beat = 0; nbeats = 0; outs = 0; blocked = 0; cyc = 0;
    exp_stall = '0;
    while (phase != P_END) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL layer_timeout phase=%0d burst=%0d of %0d", phase, burst, nb);
        break;
      end
      op_en = (phase == P_LOAD) || hold_op;
      if (phase == P_LOAD) begin
        cfg_ram_type = rt; cfg_base_addr = base; cfg_line_stride = stride;
        cfg_width = CW'(w); cfg_height = CW'(h); cfg_intr_ptr = ip; cfg_perf_en = pe;
      end else begin
        cfg_ram_type = 1'($urandom); cfg_base_addr = AAW'({$urandom, $urandom});
        cfg_line_stride = AAW'({$urandom, $urandom}); cfg_width = CW'($urandom);
        cfg_height = CW'($urandom); cfg_intr_ptr = 1'($urandom); cfg_perf_en = 1'($urandom);
      end
      sel_rdy = ($urandom_range(99) < rdy_pct) || (rsp_mode == 2 && phase == P_CMD);
      dp_valid = (phase == P_DATA) ? ($urandom_range(99) < 70) : 1'($urandom);
      for (int i = 0; i < DW / 32; i++) dp_pd[i*32 +: 32] = $urandom;
      pulse = 1'b0;
      if (phase != P_LOAD && outs > 0) begin
        case (rsp_mode)
          0:       pulse = ($urandom_range(99) < 30);
          1:       pulse = (blocked >= 4) || (phase == P_DRAIN);
          default: pulse = (phase == P_CMD) || (phase == P_DRAIN);
        endcase
      end
      if (rt) begin
        mcif_req_ready = sel_rdy; mcif_rsp_complete = pulse;
        cvif_req_ready = 1'($urandom); cvif_rsp_complete = ($urandom_range(2) == 0);
      end else begin
        cvif_req_ready = sel_rdy; cvif_rsp_complete = pulse;
        mcif_req_ready = 1'($urandom); mcif_rsp_complete = ($urandom_range(2) == 0);
      end

      @(negedge clk);
      sv  = rt ? mcif_req_valid : cvif_req_valid;
      uv  = rt ? cvif_req_valid : mcif_req_valid;
      spd = rt ? mcif_req_pd : cvif_req_pd;
      upd = rt ? cvif_req_pd : mcif_req_pd;
      exp_v = (phase == P_CMD) ? (outs < MO) : (phase == P_DATA) ? dp_valid : 1'b0;

      checks++;
      if (sv !== exp_v) begin
        errors++;
        $display("FAIL req_valid phase=%0d burst=%0d outs=%0d got %b exp %b", phase, burst, outs, sv, exp_v);
      end
      checks++;
      if (uv !== 1'b0 || upd !== '0) begin
        errors++;
        $display("FAIL unselected_if got valid=%b pd_nonzero=%b exp 0/0", uv, (upd != '0));
      end
      checks++;
      if (dp_ready !== ((phase == P_DATA) ? sel_rdy : 1'b0)) begin
        errors++;
        $display("FAIL dp_ready phase=%0d got %b exp %b", phase, dp_ready, (phase == P_DATA) && sel_rdy);
      end
      checks++;
      if (done !== (phase == P_DONE) || intr_pvld !== (phase == P_DONE)) begin
        errors++;
        $display("FAIL done_pulse phase=%0d got done=%b intr_pvld=%b exp %b", phase, done, intr_pvld, phase == P_DONE);
      end
      if (exp_v && sv === 1'b1) begin
        if (phase == P_CMD) begin
          epd = '0;
          epd[AW-1:0] = exp_addr[burst];
          epd[AW +: 4] = 4'(exp_size[burst]);
          epd[AW+4] = 1'b1;
        end else begin
          epd = {1'b1, dp_pd};
        end
        checks++;
        if (spd !== epd) begin
          errors++;
          $display("FAIL req_pd phase=%0d burst=%0d got %h exp %h", phase, burst, spd, epd);
        end
      end
      if (phase == P_DONE) begin
        checks++;
        if (intr_ptr !== ip) begin
          errors++;
          $display("FAIL intr_ptr got %b exp %b", intr_ptr, ip);
        end
        checks++;
        if (stall_cnt !== exp_stall) begin
          errors++;
          $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_stall);
        end
      end

      cmd_acc = (phase == P_CMD) && exp_v && sel_rdy;
      if (pe && exp_v && !sel_rdy && exp_stall != '1) exp_stall++;
      if (phase == P_CMD && outs >= MO) blocked++;
      if (pulse) blocked = 0;
      case (phase)
        P_LOAD: phase = P_CMD;
        P_CMD: if (cmd_acc) begin phase = P_DATA; beat = 0; end
        P_DATA: begin
          if (dp_valid && sel_rdy) begin
            beat++; nbeats++;
            if (beat == exp_size[burst] + 1) begin
              burst++;
              phase = (burst == nb) ? P_DRAIN : P_CMD;
            end
          end
        end
        P_DRAIN: if (outs == 0) phase = P_DONE;
        P_DONE: phase = P_END;
        default: ;
      endcase
      outs = outs + (cmd_acc ? 1 : 0) - (pulse ? 1 : 0);
      if (abort_beats != 0 && nbeats == abort_beats) break;
    end
  endtask

  task automatic test_reset();
    op_en = 0; cfg_ram_type = 0; cfg_base_addr = '0; cfg_line_stride = '0;
    cfg_width = '0; cfg_height = '0; cfg_intr_ptr = 0; cfg_perf_en = 0;
    dp_valid = 0; dp_pd = '0; mcif_req_ready = 1; cvif_req_ready = 1;
    mcif_rsp_complete = 0; cvif_rsp_complete = 0;
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mcif_req_valid, cvif_req_valid, dp_ready, done, intr_pvld, intr_ptr} !== 6'b0 ||
        stall_cnt !== 32'd0 || mcif_req_pd !== '0 || cvif_req_pd !== '0) begin
      errors++;
      $display("FAIL reset_values got mv=%b cv=%b rdy=%b done=%b ip=%b ptr=%b stall=%0d exp all 0",
               mcif_req_valid, cvif_req_valid, dp_ready, done, intr_pvld, intr_ptr, stall_cnt);
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_basic();
    run_layer(1'b1, 9, 1, AAW'(59'h100), AAW'(59'h40), 1'b1, 1'b1, 100, 0, 1'b0, 0);
    run_layer(1'b1, 9, 1, AAW'(59'h100), AAW'(59'h40), 1'b0, 1'b1, 60, 0, 1'b0, 0);
  endtask

  task automatic test_credit();
    run_layer(1'b1, 9, 1, AAW'(59'h200), AAW'(59'h80), 1'b1, 1'b1, 100, 1, 1'b0, 0);
  endtask

  task automatic test_same_cycle();
    run_layer(1'b1, 13, 1, AAW'(59'h30), AAW'(59'h20), 1'b0, 1'b0, 100, 2, 1'b0, 0);
  endtask

  task automatic test_cvif_stall();
    run_layer(1'b0, 13, 2, AAW'(59'h1234), AAW'(59'h100), 1'b1, 1'b1, 50, 0, 1'b0, 0);
  endtask

  task automatic test_boundaries();
    run_layer(1'b1, 0, 2, AAW'(59'h10), AAW'(59'h3), 1'b0, 1'b1, 70, 0, 1'b0, 0);
    run_layer(1'b0, 7, 0, AAW'(59'h50), AAW'(59'h0), 1'b1, 1'b0, 70, 0, 1'b0, 0);
    run_layer(1'b1, 5, 1, {AAW{1'b1}} - AAW'(1), {AAW{1'b1}}, 1'b0, 1'b1, 80, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      run_layer(1'($urandom), $urandom_range(20), $urandom_range(3),
                AAW'({$urandom, $urandom}), AAW'({$urandom, $urandom}),
                1'($urandom), 1'($urandom), $urandom_range(40, 100), $urandom_range(2), 1'b0, 0);
    end
  endtask

  task automatic test_reset_abort();
    run_layer(1'b1, 9, 1, AAW'(59'h100), AAW'(59'h40), 1'b1, 1'b1, 60, 0, 1'b0, 6);
    @(posedge clk); #2;
    rstn = 0;
    #1;
    checks++;
    if ({mcif_req_valid, cvif_req_valid, dp_ready, done, intr_pvld, intr_ptr} !== 6'b0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort_async got mv=%b rdy=%b ptr=%b stall=%0d exp all 0",
               mcif_req_valid, dp_ready, intr_ptr, stall_cnt);
    end
    op_en = 0;
    @(posedge clk); #1;
    checks++;
    if ({mcif_req_valid, cvif_req_valid, dp_ready, done, intr_pvld} !== 5'b0 || mcif_req_pd !== '0) begin
      errors++;
      $display("FAIL reset_abort_edge got mv=%b rdy=%b done=%b exp 0", mcif_req_valid, dp_ready, done);
    end
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
    mcif_rsp_complete = 1;
    @(posedge clk); #1;
    mcif_rsp_complete = 0;
    run_layer(1'b1, 9, 1, AAW'(59'h100), AAW'(59'h40), 1'b0, 1'b1, 60, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_layer(1'b1, 5, 0, AAW'(59'h400), AAW'(59'h10), 1'b0, 1'b1, 80, 0, 1'b1, 0);
    run_layer(1'b0, 6, 1, AAW'(59'h800), AAW'(59'h20), 1'b1, 1'b1, 80, 0, 1'b1, 0);
    op_en = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_same_cycle();
    test_cvif_stall();
    test_boundaries();
    test_random();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvdla_sdp_wdma_burst_engine.md
Name: nvdla_sdp_wdma_burst_engine

Overview:
- Parametrised next-generation SDP write-DMA engine.
- Walks an output surface line by line and splits each line into bursts of at most MAX_BURST atoms.
- Emits a command beat followed by data beats onto MCIF or CVIF, as selected by ram type.
- Limits outstanding bursts by credit and tracks write completions; done and interrupt are raised only after every response has returned. Stall cycles are counted for perf.

Parameters:
- DW, 256, data beat width in bits (one atom per beat).
- AW, 64, byte address width.
- ATOM_LOG2, 5, log2 of atom bytes; addresses and strides are supplied in atom units.
- MAX_BURST, 4, max atoms per burst, power of 2, from 1 to 16.
- MAX_OUTS, 16, max outstanding bursts awaiting completion.
- CNT_W, 13, width of width/height fields.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  async active-low reset
- op_en  in  1  start request; level, sampled when idle
- cfg_ram_type  in  1  0=CVIF, 1=MCIF; latched at start
- cfg_base_addr  in  AW-ATOM_LOG2  surface base, atom units
- cfg_line_stride  in  AW-ATOM_LOG2  line stride, atom units
- cfg_width  in  CNT_W  atoms per line minus 1
- cfg_height  in  CNT_W  lines minus 1
- cfg_intr_ptr  in  1  interrupt pointer echoed at done
- cfg_perf_en  in  1  enable stall counter
- dp_valid  in  1  upstream data valid
- dp_ready  out  1  upstream data ready
- dp_pd  in  DW  upstream atom
- mcif_req_valid/cvif_req_valid  out  1  request valid, per interface
- mcif_req_ready/cvif_req_ready  in  1  request ready
- mcif_req_pd/cvif_req_pd  out  DW+1  bit DW is type (0=cmd, 1=data). Cmd payload layout: [AW-1:0] addr, [AW+3:AW] size=atoms-1, [AW+4] require_ack=1.
- mcif_rsp_complete/cvif_rsp_complete  in  1  one-cycle completion pulse
- done  out  1  one-cycle pulse at layer end
- intr_pvld  out  1  one-cycle pulse, coincident with done
- intr_ptr  out  1  latched cfg_intr_ptr
- stall_cnt  out  32  req valid && !ready cycles, saturating

Behaviour:
- Reset values: all valids 0, dp_ready 0, done 0, intr_pvld 0, intr_ptr 0, stall_cnt 0, outstanding 0, state IDLE.
- FSM states: IDLE, CMD, DATA, DRAIN, DONE.
- IDLE -> CMD when op_en=1. That cycle (op_load): latch all cfg_*, clear line, burst and outstanding counters, clear stall_cnt.
- CMD:
  - Burst size = min(MAX_BURST, remaining atoms in the line).
  - Burst addr = (base + line*line_stride + atom_offset) << ATOM_LOG2, truncated to AW.
  - The command is registered; req_valid is asserted only when outstanding < MAX_OUTS.
  - On accept: outstanding += 1, then go to DATA.
- DATA:
  - Combinational pass-through: req_valid = dp_valid, dp_ready = sel_req_ready, pd = {1, dp_pd}.
  - Zero latency, no buffering.
  - After size+1 accepted beats: if this was the last burst of the last line, go to DRAIN; otherwise go to CMD with offset/line advanced.
  - At line end, the offset resets to 0 and the line increments.
- Bursts never span lines.
- DRAIN -> DONE when outstanding == 0.
- DONE: assert done and intr_pvld for exactly 1 cycle, then go to IDLE.
- Outstanding counter:
  - +1 on cmd accept; -1 on selected-interface rsp_complete; unchanged when both occur in the same cycle.
  - Width is clog2(MAX_OUTS+1).
  - The unselected interface's rsp_complete is ignored.
- Interface select:
  - The unselected interface's valid is held 0 and its pd is driven 0.
  - Ready is taken only from the selected interface.
- stall_cnt increments when cfg_perf_en && sel valid && !sel ready. It saturates at 0xFFFFFFFF and holds its value after done until the next op_load.
- op_en while not IDLE is ignored. Config changes mid-layer have no effect.
- Async reset mid-operation aborts immediately to reset values. Responses arriving afterwards are ignored.
- Boundaries:
  - cfg_width=0 gives 1-atom bursts.
  - A width that is an exact multiple of MAX_BURST has no remainder burst.
  - cfg_height=0 gives a single line.
  - Address add wraps modulo 2^AW.

Decomposition:
- Package nvdla_sdp_wdma_pkg holds the FSM state enum, the pd type localparams (PD_CMD=0, PD_DAT=1), cmd field offset constants and the clog2-derived counter widths.
- One sub-module: nvdla_sdp_wdma_credit, the outstanding counter with full/empty flags.

Test Plan:
- Settings MAX_BURST=4, width=9 (10 atoms), height=1, base=0x100, stride=0x40, MCIF -> 6 bursts at byte addrs 0x2000/0x2080/0x2100 with sizes 3/3/1, then 0x2800/0x2880/0x2900; 20 data beats; done 1 cycle after the last completion.
- MAX_OUTS=2, responses withheld -> 3rd cmd valid stays 0 until one rsp_complete pulse arrives; then issues the next cycle.
- cmd accept and rsp_complete in the same cycle with outstanding=1 -> outstanding stays 1; done occurs only after the final pulse.
- ram_type=0, cvif_req_ready toggling 50%, perf_en=1 -> mcif_req_valid always 0; stall_cnt equals the counted cvif stall cycles; mcif_rsp_complete pulses ignored.
- Reset asserted during DATA of burst 2 -> all outputs 0 next edge; a new op_en afterwards restarts at base with stall_cnt=0.
- op_en held high through done -> second layer starts exactly 1 cycle after IDLE is reached; intr_ptr reflects the new cfg_intr_ptr.
